// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS datapath: ALU op codes, opcodes, reset vector.
package mips_pkg;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0]  OP_BNE       = 6'b000101;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/single_cycle_datapath_regfile.sv
// 32x32 register file: two async read ports, one sync write port, R0 hardwired to 0.
// DATAPATH_REGFILE_CLEAR_EN: when defined, active-low reset also clears every register.
module regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] rf [0:31];

`ifdef DATAPATH_REGFILE_CLEAR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && wa != '0) begin
      rf[wa] <= wd;
    end
  end
`else
  // Reset low on the edge still blocks the write, even though contents are not cleared.
  always_ff @(posedge clk) begin
    if (reset && we && wa != '0) rf[wa] <= wd;
  end
`endif

  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];
endmodule

// File: rtl/single_cycle_datapath.sv
// Single-cycle MIPS datapath: PC, register file, sign-extend, ALU and next-PC selection.
// Optional build macro DATAPATH_REGFILE_CLEAR_EN clears the register file on reset.
module single_cycle_datapath
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoreg,
  input  logic        pcsrc,
  input  logic        alusrc,
  input  logic        regdst,
  input  logic        regwrite,
  input  logic        jump,
  input  logic        jr,
  input  logic [2:0]  alucontrol,
  output logic        zeroNzero,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] aluout,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);
  logic [31:0] srca, srcb, rd2, signimm, result;
  logic [31:0] pcplus4, pcbranch, pcnext;
  logic [4:0]  writereg;

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .wa    (writereg),
    .wd    (result),
    .rd1   (srca),
    .rd2   (rd2)
  );

  assign signimm   = {{16{instr[15]}}, instr[15:0]};
  assign srcb      = alusrc ? signimm : rd2;
  assign writedata = rd2;
  assign writereg  = regdst ? instr[15:11] : instr[20:16];
  assign result    = memtoreg ? readdata : aluout;

  always_comb begin
    aluout = '0;
    case (alucontrol)
      ALU_AND: aluout = srca & srcb;
      ALU_OR:  aluout = srca | srcb;
      ALU_ADD: aluout = srca + srcb;
      ALU_SUB: aluout = srca - srcb;
      ALU_SLT: aluout = {31'b0, $signed(srca) < $signed(srcb)};
      default: aluout = '0;
    endcase
  end

  // BNE reuses the SUB zero test, so the flag is inverted for that opcode only.
  assign zeroNzero = (aluout == '0) ^ (instr[31:26] == OP_BNE);

  assign pcplus4  = pc + 32'd4;
  assign pcbranch = pcplus4 + {signimm[29:0], 2'b00};

  always_comb begin
    pcnext = pcplus4;
    if (jr)         pcnext = srca;
    else if (jump)  pcnext = {pcplus4[31:28], instr[25:0], 2'b00};
    else if (pcsrc) pcnext = pcbranch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_VECTOR;
    else        pc <= pcnext;
  end
endmodule

// File: tb/tb_single_cycle_datapath.sv
// Scoreboard bench for single_cycle_datapath: directed program then randomized instructions.
module tb_single_cycle_datapath;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        memtoreg, pcsrc, alusrc, regdst, regwrite, jump, jr;
  logic [2:0]  alucontrol;
  logic        zeroNzero;
  logic [31:0] pc, instr, aluout, writedata, readdata;

  single_cycle_datapath dut (
    .clk        (clk),
    .reset      (reset_n),
    .memtoreg   (memtoreg),
    .pcsrc      (pcsrc),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .jump       (jump),
    .jr         (jr),
    .alucontrol (alucontrol),
    .zeroNzero  (zeroNzero),
    .pc         (pc),
    .instr      (instr),
    .aluout     (aluout),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] C_MTR = 7'b1000000, C_PS = 7'b0100000, C_AS = 7'b0010000,
                         C_RD  = 7'b0001000, C_RW = 7'b0000100, C_J  = 7'b0000010,
                         C_JR  = 7'b0000001;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                         A_SUB = 3'b110, A_SLT = 3'b111;

  typedef struct {
    logic [31:0] pc, alu, wd;
    logic        z;
    bit          pin_pc_v, pin_alu_v, pin_z_v;
    logic [31:0] pin_pc, pin_alu;
    logic        pin_z;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  // Architectural state of the reference machine.
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];

  bit          pin_pc_v, pin_alu_v, pin_z_v;
  logic [31:0] pin_pc, pin_alu;
  logic        pin_z;

  function automatic logic [31:0] rreg(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("aluout", aluout, e.alu);
      chk("writedata", writedata, e.wd);
      chk("zeroNzero", {31'd0, zeroNzero}, {31'd0, e.z});
      if (e.pin_pc_v)  chk("pc_plan", pc, e.pin_pc);
      if (e.pin_alu_v) chk("aluout_plan", aluout, e.pin_alu);
      if (e.pin_z_v)   chk("zero_plan", {31'd0, zeroNzero}, {31'd0, e.pin_z});
    end
  end

  task automatic assert_reset();
    reset_n = 1'b0;
    m_pc = 32'h0;
`ifdef DATAPATH_REGFILE_CLEAR_EN
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
`endif
  endtask

  // Drive one instruction, push its expected outputs, then advance the model across the edge.
  task automatic step(input logic [31:0] in, input logic [2:0] ac, input logic [6:0] c,
                      input logic [31:0] rdat);
    exp_t        e;
    logic [31:0] sa, b2, simm, alu, p4, np, wdat;
    logic [4:0]  wa;
    {memtoreg, pcsrc, alusrc, regdst, regwrite, jump, jr} = c;
    instr = in; alucontrol = ac; readdata = rdat;
    sa   = rreg(in[25:21]);
    b2   = rreg(in[20:16]);
    simm = {{16{in[15]}}, in[15:0]};
    if (alusrc) b2 = simm;
    case (ac)
      A_AND:   alu = sa & b2;
      A_OR:    alu = sa | b2;
      A_ADD:   alu = sa + b2;
      A_SUB:   alu = sa - b2;
      A_SLT:   alu = ($signed(sa) < $signed(b2)) ? 32'd1 : 32'd0;
      default: alu = 32'd0;
    endcase
    e.pc = m_pc; e.alu = alu; e.wd = rreg(in[20:16]);
    e.z  = (alu == 32'd0) != (in[31:26] == 6'b000101);
    e.pin_pc_v = pin_pc_v; e.pin_pc = pin_pc;
    e.pin_alu_v = pin_alu_v; e.pin_alu = pin_alu;
    e.pin_z_v = pin_z_v; e.pin_z = pin_z;
    pin_pc_v = 0; pin_alu_v = 0; pin_z_v = 0;
    sb.push_back(e);
    p4 = m_pc + 32'd4;
    if (jr)         np = sa;
    else if (jump)  np = {p4[31:28], in[25:0], 2'b00};
    else if (pcsrc) np = p4 + simm * 4;
    else            np = p4;
    wa   = regdst ? in[15:11] : in[20:16];
    wdat = memtoreg ? rdat : alu;
    @(posedge clk);
    #1;
    if (reset_n) begin
      m_pc = np;
      if (regwrite && wa != 5'd0) m_regs[wa] = wdat;
    end
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rt, input logic [15:0] imm);
    return {6'b001000, 5'd0, rt, imm};
  endfunction

  initial begin
    pin_pc_v = 0; pin_alu_v = 0; pin_z_v = 0;
    pin_pc = '0; pin_alu = '0; pin_z = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    {memtoreg, pcsrc, alusrc, regdst, regwrite, jump, jr} = '0;
    alucontrol = '0; instr = '0; readdata = '0;
    assert_reset();
    @(posedge clk);
    #1;

    // Reset held, then released: 0, 0, then 4, 8.
    pin_pc_v = 1; pin_pc = 32'h0; step(32'h0, A_AND, '0, '0);
    pin_pc_v = 1; pin_pc = 32'h0; step(32'h0, A_AND, '0, '0);
    reset_n = 1'b1;
    pin_pc_v = 1; pin_pc = 32'h0; step(32'h0, A_AND, '0, '0);
    pin_pc_v = 1; pin_pc = 32'h4; step(32'h0, A_AND, '0, '0);
    pin_pc_v = 1; pin_pc = 32'h8; step(32'h0800000A, A_AND, C_J, '0);
    pin_pc_v = 1; pin_pc = 32'h28; pin_z_v = 1; pin_z = 1'b1;
    step(32'h1000FFFC, A_SUB, C_PS, '0);
    pin_pc_v = 1; pin_pc = 32'h1C; pin_alu_v = 1; pin_alu = 32'h100;
    step(32'h20080100, A_ADD, C_AS | C_RW, '0);
    pin_pc_v = 1; pin_pc = 32'h20; step(32'h01000008, A_ADD, C_JR, '0);
    pin_pc_v = 1; pin_pc = 32'h100; step(32'h20000055, A_ADD, C_AS | C_RW, '0);
    pin_alu_v = 1; pin_alu = 32'h77; step(32'h20000077, A_ADD, C_AS, '0);

    // Give every register a known value before random traffic reads it.
    for (int unsigned i = 1; i < 32; i++) begin
      logic [31:0] r;
      r = i;
      step(addi(r[4:0], $urandom), A_ADD, C_AS | C_RW, '0);
    end
    step(addi(5'd9, 16'd5), A_ADD, C_AS | C_RW, '0);
    step(addi(5'd10, 16'd5), A_ADD, C_AS | C_RW, '0);
    step(addi(5'd11, 16'd6), A_ADD, C_AS | C_RW, '0);
    pin_z_v = 1; pin_z = 1'b0; step({6'b000101, 5'd9, 5'd10, 16'd3}, A_SUB, '0, '0);
    pin_z_v = 1; pin_z = 1'b1; step({6'b000101, 5'd9, 5'd11, 16'd3}, A_SUB, '0, '0);
    pin_z_v = 1; pin_z = 1'b1; step({6'b000100, 5'd9, 5'd10, 16'd3}, A_SUB, '0, '0);
    pin_alu_v = 1; pin_alu = 32'd1; step({6'b0, 5'd9, 5'd11, 11'd0}, A_SLT, '0, '0);

    // Random instructions with occasional mid-run reset pulses.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] c;
      c = 7'($urandom);
      if ($urandom_range(0, 2) == 0) c = c & ~(C_J | C_JR);
      if ($urandom_range(0, 39) == 0) begin
        assert_reset();
        step($urandom, 3'($urandom), c | C_RW, $urandom);
        reset_n = 1'b1;
`ifdef DATAPATH_REGFILE_CLEAR_EN
        for (int unsigned i = 1; i < 32; i++) begin
          logic [31:0] r;
          r = i;
          step(addi(r[4:0], $urandom), A_ADD, C_AS | C_RW, '0);
        end
`endif
      end else begin
        step($urandom, 3'($urandom), c, $urandom);
      end
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
